// File: rtl/clk_gate_pkg.sv
// rtl/clk_gate_pkg.sv - shared types and constants for the clock-gate controller
package clk_gate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } clk_gate_state_e;

  localparam int GATED_CNT_W = 32;

  // One counter serves both IDLE and WAKE, so size it for the larger of the two.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clk_gate_sat_cnt.sv
// rtl/clk_gate_sat_cnt.sv - saturating clearable counter of gated cycles
module clk_gate_sat_cnt
  import clk_gate_pkg::*;
#(
  parameter logic [GATED_CNT_W-1:0] RST_VAL = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_inc,
  input  logic                   i_clr,
  output logic [GATED_CNT_W-1:0] o_count
);

  logic [GATED_CNT_W-1:0] r_count;

  // Clear takes priority over increment; the count sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= RST_VAL;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + GATED_CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - idle-detect FSM producing a glitch-free clock enable
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int                     IDLE_CYCLES   = 16,
  parameter int                     WAKE_CYCLES   = 2,
  parameter logic [GATED_CNT_W-1:0] GATED_CNT_RST = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sleep_req_i,
  input  logic                   busy_i,
  input  logic                   wake_i,
  input  logic                   test_en_i,
  input  logic                   cnt_clr_i,
  output logic                   clk_en_o,
  output logic                   sleeping_o,
  output logic                   wake_ack_o,
  output logic [GATED_CNT_W-1:0] gated_cycles_o
);

  localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  clk_gate_state_e  r_state;
  clk_gate_state_e  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ack_nxt;
  logic             w_quiet;
  logic             r_sleeping;
  logic             r_wake_ack;
  logic             r_clk_en;

  assign w_quiet = sleep_req_i && !busy_i && !wake_i && !test_en_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_quiet) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      IDLE: begin
        if (!w_quiet) begin
          w_state_nxt = RUN;
        end else if (r_cnt == IDLE_LAST) begin
          w_state_nxt = GATED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GATED: begin
        if (!w_quiet) begin
          w_state_nxt = WAKE;
          w_cnt_nxt   = '0;
        end
      end
      WAKE: begin
        // Inputs are deliberately ignored until the clock has run WAKE_CYCLES.
        if (r_cnt == WAKE_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_sleeping <= 1'b0;
      r_wake_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sleeping <= (w_state_nxt == GATED);
      r_wake_ack <= w_ack_nxt;
    end
  end

  // Falling-edge flop: the enable only moves while clk_i is low.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r_clk_en <= 1'b1;
    end else begin
      r_clk_en <= (r_state != GATED);
    end
  end

  clk_gate_sat_cnt #(
    .RST_VAL (GATED_CNT_RST)
  ) u_sat_cnt (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_inc   (r_state == GATED),
    .i_clr   (cnt_clr_i),
    .o_count (gated_cycles_o)
  );

  assign clk_en_o   = r_clk_en;
  assign sleeping_o = r_sleeping;
  assign wake_ack_o = r_wake_ack;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - vector-table and scoreboard bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

  typedef struct packed {
    logic        rst, sleep, busy, wake, test, clr;
    logic        e_sl, e_en, e_ack;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, sleep_a = 1'b0, busy_a = 1'b0, wake_a = 1'b0, test_a = 1'b0, clr_a = 1'b0;
  logic        rst_b = 1'b1, sleep_b = 1'b0, busy_b = 1'b0, wake_b = 1'b0, test_b = 1'b0, clr_b = 1'b0;
  logic        en_a, sl_a, ack_a, en_b, sl_b, ack_b;
  logic [31:0] cnt_a, cnt_b;

  clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .sleep_req_i(sleep_a), .busy_i(busy_a), .wake_i(wake_a),
    .test_en_i(test_a), .cnt_clr_i(clr_a), .clk_en_o(en_a), .sleeping_o(sl_a),
    .wake_ack_o(ack_a), .gated_cycles_o(cnt_a)
  );

  // Second instance: minimal thresholds and a counter preloaded near saturation.
  clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1), .GATED_CNT_RST(32'hFFFF_FFFE)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .sleep_req_i(sleep_b), .busy_i(busy_b), .wake_i(wake_b),
    .test_en_i(test_b), .cnt_clr_i(clr_b), .clk_en_o(en_b), .sleeping_o(sl_b),
    .wake_ack_o(ack_b), .gated_cycles_o(cnt_b)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];
  logic prev_en;
  bit   prev_valid;

  function automatic vec_t mk(input logic rst, sleep, busy, wake, test, clr,
                              input logic sl, en, ack, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.sleep = sleep; v.busy = busy; v.wake = wake; v.test = test; v.clr = clr;
    v.e_sl = sl; v.e_en = en; v.e_ack = ack; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic run_step(input bit sel, input vec_t v);
    vec_t e;
    if (!sel) begin
      rst_a = v.rst; sleep_a = v.sleep; busy_a = v.busy; wake_a = v.wake; test_a = v.test; clr_a = v.clr;
    end else begin
      rst_b = v.rst; sleep_b = v.sleep; busy_b = v.busy; wake_b = v.wake; test_b = v.test; clr_b = v.clr;
    end
    exp_q.push_back(v);
    @(posedge clk); #1;
    // Enable must not move until the following falling edge.
    if (prev_valid) chk(sel ? "b_en_half" : "a_en_half", 32'(sel ? en_b : en_a), 32'(prev_en));
    @(negedge clk); #1;
    e = exp_q.pop_front();
    chk(sel ? "b_sleeping" : "a_sleeping", 32'(sel ? sl_b  : sl_a),  32'(e.e_sl));
    chk(sel ? "b_clk_en"   : "a_clk_en",   32'(sel ? en_b  : en_a),  32'(e.e_en));
    chk(sel ? "b_wake_ack" : "a_wake_ack", 32'(sel ? ack_b : ack_a), 32'(e.e_ack));
    chk(sel ? "b_gated"    : "a_gated",    sel ? cnt_b : cnt_a,      e.e_cnt);
    prev_en    = e.e_en;
    prev_valid = 1'b1;
  endtask

  initial begin
    // Instance A: nominal gating, wake, clear, abort, reset mid-sleep.
    tbl_a.push_back(mk(1,0,0,0,0,0, 0,1,0,0));
    for (int i = 0; i < 4; i++) tbl_a.push_back(mk(0,1,0,0,0,0, 0,1,0,0));
    tbl_a.push_back(mk(0,1,0,0,0,0, 1,0,0,0));
    for (int i = 1; i <= 9; i++) tbl_a.push_back(mk(0,1,0,0,0,0, 1,0,0,32'(i)));
    tbl_a.push_back(mk(0,1,0,1,0,0, 0,1,0,10));
    tbl_a.push_back(mk(0,1,0,0,0,0, 0,1,0,10));
    tbl_a.push_back(mk(0,1,0,0,0,0, 0,1,1,10));
    tbl_a.push_back(mk(0,0,0,0,0,0, 0,1,0,10));
    tbl_a.push_back(mk(0,0,0,0,0,1, 0,1,0,0));
    tbl_a.push_back(mk(0,1,0,0,0,0, 0,1,0,0));
    tbl_a.push_back(mk(0,1,0,0,0,0, 0,1,0,0));
    tbl_a.push_back(mk(0,1,1,0,0,0, 0,1,0,0));
    tbl_a.push_back(mk(0,1,0,1,0,0, 0,1,0,0));
    for (int i = 0; i < 4; i++) tbl_a.push_back(mk(0,1,0,0,0,0, 0,1,0,0));
    tbl_a.push_back(mk(0,1,0,0,0,0, 1,0,0,0));
    tbl_a.push_back(mk(0,1,0,0,0,1, 1,0,0,0));
    tbl_a.push_back(mk(0,1,0,0,0,0, 1,0,0,1));
    tbl_a.push_back(mk(1,1,0,0,0,0, 0,1,0,0));
    tbl_a.push_back(mk(0,0,0,0,0,0, 0,1,0,0));
    tbl_a.push_back(mk(0,0,0,0,0,0, 0,1,0,0));
    for (int i = 0; i < 100; i++) tbl_a.push_back(mk(0,1,0,0,1,0, 0,1,0,0));
    tbl_a.push_back(mk(0,0,0,0,0,0, 0,1,0,0));

    // Instance B: one-cycle thresholds, saturation, clear-vs-increment, reset in WAKE.
    tbl_b.push_back(mk(1,0,0,0,0,0, 0,1,0,32'hFFFF_FFFE));
    tbl_b.push_back(mk(0,1,0,0,0,0, 0,1,0,32'hFFFF_FFFE));
    tbl_b.push_back(mk(0,1,0,0,0,0, 1,0,0,32'hFFFF_FFFE));
    for (int i = 0; i < 3; i++) tbl_b.push_back(mk(0,1,0,0,0,0, 1,0,0,32'hFFFF_FFFF));
    tbl_b.push_back(mk(0,1,0,0,0,1, 1,0,0,0));
    tbl_b.push_back(mk(0,1,0,0,0,0, 1,0,0,1));
    tbl_b.push_back(mk(0,1,0,1,0,0, 0,1,0,2));
    tbl_b.push_back(mk(0,1,0,0,0,0, 0,1,1,2));
    tbl_b.push_back(mk(0,0,0,0,0,0, 0,1,0,2));
    tbl_b.push_back(mk(0,1,0,0,0,0, 0,1,0,2));
    tbl_b.push_back(mk(0,1,0,0,0,0, 1,0,0,2));
    tbl_b.push_back(mk(0,1,0,1,0,0, 0,1,0,3));
    tbl_b.push_back(mk(1,1,0,0,0,0, 0,1,0,32'hFFFF_FFFE));
    tbl_b.push_back(mk(0,0,0,0,0,0, 0,1,0,32'hFFFF_FFFE));

    prev_valid = 1'b0;
    prev_en    = 1'b1;
    foreach (tbl_a[i]) run_step(1'b0, tbl_a[i]);

    prev_valid = 1'b0;
    foreach (tbl_b[i]) run_step(1'b1, tbl_b[i]);

    // Reset in GATED must raise the enable at the very next falling edge.
    run_step(1'b1, mk(0,1,0,0,0,0, 0,1,0,32'hFFFF_FFFE));
    run_step(1'b1, mk(0,1,0,0,0,0, 1,0,0,32'hFFFF_FFFE));
    rst_b = 1'b1;
    @(negedge clk); #1;
    chk("b_rst_en_negedge", 32'(en_b), 32'd1);
    @(posedge clk); #1;
    chk("b_rst_sleeping", 32'(sl_b), 32'd0);
    chk("b_rst_no_ack", 32'(ack_b), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
